arm_data_mem_ctrl: RTL and testbench
====================================

Name: arm_data_mem_ctrl

Overview:
- Parametrised successor to the single-cycle data memory used beside the ARMV4 core.
- Adds a multi-cycle req/ready handshake with configurable wait states.
- Adds byte (LDRB/STRB) and word access, and error reporting.
- Adds a small memory-mapped I/O region: an LED register and a free-running cycle counter.
- Sits between the core's data port and RAM; the multi-cycle core stalls on ready.

Parameters:
- DEPTH_WORDS, 64: RAM depth in 32-bit words; power of two, 4..4096.
- WAIT_STATES, 2: extra cycles per access; 0..15.
- LED_W, 8: width of the LED register, 1..32.
- MMIO_BASE, 32'h0000_F000: base of the MMIO region; 4 KB aligned, must be at or above DEPTH_WORDS*4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; captured with req.
- byte_en  in  1  1 = byte access, 0 = word access; captured with req.
- addr  in  32  byte address; captured with req.
- wdata  in  32  write data; for byte writes lane 0 (wdata[7:0]) is used.
- rdata  out  32  read data; valid in the ready cycle, held until the next completion.
- ready  out  1  one-cycle completion pulse.
- err  out  1  pulses with ready when the access was illegal.
- busy  out  1  high from the cycle after req is accepted until ready, inclusive.
- led_out  out  LED_W  LED register contents.

Behaviour:
- Reset values (synchronous, active-high):
  - State IDLE; ready, err, busy, rdata, led_out and cycle counter all 0.
  - RAM contents are not cleared.
- Reset mid-transaction: access aborted, no write committed, no ready pulse.
- FSM states IDLE, WAIT, DONE.
  - IDLE + req=1: latch we/byte_en/addr/wdata. Go to WAIT with wait counter = WAIT_STATES, or straight to DONE if WAIT_STATES=0.
  - WAIT: decrement wait counter each cycle; move to DONE when it reaches 1.
  - DONE: single cycle. Commit write or drive rdata, pulse ready (and err if illegal), return to IDLE.
- Latency: ready asserts exactly WAIT_STATES+1 cycles after the edge that samples req. Back-to-back: req high in the ready cycle is not sampled; the next access starts the cycle after.
- req, addr and all other inputs are ignored while busy=1. Changing them mid-access has no effect.
- Decode on the latched address:
  - addr < DEPTH_WORDS*4: RAM. Word index = addr[log2(DEPTH_WORDS)+1:2].
  - MMIO_BASE+0: LED register, read/write.
    - Write sets led_out to wdata[LED_W-1:0] (byte write: lane 0 only, upper bits of the register kept).
    - Read returns the register zero-extended to 32 bits.
  - MMIO_BASE+4: cycle counter, read-only.
    - 32-bit, increments every cycle out of reset, wraps 0xFFFF_FFFF -> 0.
    - Read returns the counter value at the DONE edge.
    - Write sets err=1; the counter is unchanged.
  - Anything else is illegal: err=1, rdata=0, no state change.
- Word access with addr[1:0] != 0 is misaligned: err=1, no write, rdata=0.
- Byte access (little-endian):
  - Read returns the byte at lane addr[1:0], zero-extended to 32 bits.
  - Write updates only that lane with wdata[7:0]; the other lanes are untouched.
- rdata on a write completion: unchanged from the previous value.
- rdata on an error completion: 0.
- err is 0 whenever ready is 0.

Test Plan:
- Reset, then word write 0xDEADBEEF to 0x10 with WAIT_STATES=2, then word read 0x10 -> ready 3 cycles after each req, rdata=0xDEADBEEF, err=0.
- Byte write 0xA5 to 0x11 over word 0x11223344 at 0x10, then read bytes 0x10..0x13 and word 0x10 -> bytes 0x44, 0xA5, 0x22, 0x11; word 0x1122A544.
- Word read at 0x12, and word write to 0x400 (DEPTH_WORDS=64) -> err=1 with ready, rdata=0, RAM word at 0x400 & 0xFF unchanged.
- Write 0x1FF to MMIO_BASE (LED_W=8), then read it -> led_out=0xFF, rdata=0x000000FF. Write to MMIO_BASE+4 -> err=1, counter keeps counting.
- Two counter reads separated by 10 idle cycles -> difference = 10 + WAIT_STATES + 1 (13 for WAIT_STATES=2). Force the counter near 0xFFFF_FFFF and confirm it wraps to 0.
- Assert reset during WAIT of a write to 0x20 -> no ready pulse, word at 0x20 unchanged, led_out=0. Hold req high through the ready cycle -> exactly one new access is sampled, on the following cycle.

Source files
------------

// File: rtl/arm_data_mem_ctrl_if.sv
// Core-side data port bundle for arm_data_mem_ctrl: request fields from the core,
// completion pulse, status and read data back from the controller.
interface arm_data_mem_ctrl_if;
    logic        req;
    logic        we;
    logic        byte_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, byte_en, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, byte_en, addr, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/arm_data_mem_ctrl.sv
// Multi-cycle data memory controller for the ARMV4 core: RAM with byte/word access,
// configurable wait states, an LED register and a free-running cycle counter.
module arm_data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned LED_W       = 8,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_F000
) (
    input  logic               clk,
    input  logic               reset,
    arm_data_mem_ctrl_if.slave bus,
    output logic [LED_W-1:0]   led_out
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] LED_ADDR  = MMIO_BASE;
    localparam logic [31:0] CNT_ADDR  = MMIO_BASE + 32'd4;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic          we_q;
    logic          byte_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   cycle_cnt;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0]    word_idx;
    logic             hit_ram;
    logic             hit_led;
    logic             hit_cnt;
    logic             illegal;
    logic             ram_we;
    logic [31:0]      ram_word;
    logic [31:0]      src_word;
    logic [31:0]      shifted;
    logic [31:0]      rd_value;
    logic [31:0]      ram_wdata;
    logic [31:0]      led_ext;
    logic [LED_W-1:0] led_next;

    // Decode works only on the latched request, so bus changes mid-access are invisible.
    always_comb begin
        word_idx = addr_q[AW+1:2];
        hit_ram  = addr_q < RAM_BYTES;
        hit_led  = addr_q == LED_ADDR;
        hit_cnt  = addr_q == CNT_ADDR;
        illegal  = (!byte_q && addr_q[1:0] != 2'b00)
                 || !(hit_ram || hit_led || hit_cnt)
                 || (hit_cnt && we_q);
        ram_word = mem[word_idx];
        led_ext  = 32'(led_out);
        if (hit_ram)
            src_word = ram_word;
        else if (hit_led)
            src_word = led_ext;
        else
            src_word = cycle_cnt;
        shifted  = src_word >> {addr_q[1:0], 3'b000};
        rd_value = byte_q ? (shifted & 32'h0000_00FF) : src_word;
        ram_wdata = byte_q ? ram_word : wdata_q;
        if (byte_q)
            ram_wdata[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        led_next = byte_q ? LED_W'((led_ext & ~32'h0000_00FF) | 32'(wdata_q[7:0]))
                          : wdata_q[LED_W-1:0];
        ram_we   = (state == DONE) && we_q && hit_ram && !illegal && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.rdata <= '0;
            led_out   <= '0;
        end else begin
            case (state)
                // busy still high here means this is the ready cycle, where req is ignored
                IDLE: begin
                    bus.ready <= 1'b0;
                    bus.err   <= 1'b0;
                    bus.busy  <= bus.req && !bus.busy;
                    if (bus.req && !bus.busy) begin
                        we_q     <= bus.we;
                        byte_q   <= bus.byte_en;
                        addr_q   <= bus.addr;
                        wdata_q  <= bus.wdata;
                        wait_cnt <= WAIT_INIT;
                        state    <= (WAIT_STATES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1)
                        state <= DONE;
                end
                DONE: begin
                    bus.ready <= 1'b1;
                    bus.err   <= illegal;
                    if (illegal)
                        bus.rdata <= '0;
                    else if (!we_q)
                        bus.rdata <= rd_value;
                    if (we_q && hit_led && !illegal)
                        led_out <= led_next;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[word_idx] <= ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cycle_cnt <= '0;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end
endmodule

// File: tb/tb_arm_data_mem_ctrl.sv
// Self-checking bench for arm_data_mem_ctrl: directed steps plus randomized accesses
// compared against a byte-level memory/LED/counter reference model.
module tb_arm_data_mem_ctrl;
    localparam int unsigned DEPTH_WORDS = 64;
    localparam int unsigned WAIT_STATES = 2;
    localparam int unsigned LED_W       = 8;
    localparam logic [31:0] MMIO_BASE   = 32'h0000_F000;
    localparam logic [31:0] CNT_ADDR    = MMIO_BASE + 32'd4;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic [LED_W-1:0] led_out;

    arm_data_mem_ctrl_if bus();

    arm_data_mem_ctrl #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .WAIT_STATES(WAIT_STATES),
        .LED_W      (LED_W),
        .MMIO_BASE  (MMIO_BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .led_out(led_out)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          failures  = 0;
    logic [31:0] edges     = '0;
    logic [31:0] base_edge = '0;
    logic [31:0] base_val  = '0;
    logic [31:0] mdl_mem [DEPTH_WORDS];
    logic [7:0]  mdl_led   = '0;
    logic [31:0] mdl_rdata = '0;

    // Reference counter value after edge n is base_val + (n - base_edge).
    always @(posedge clk) edges <= edges + 32'd1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelAccess(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] cnt_val, output logic e, output logic [31:0] rd);
        logic        in_ram, is_led, is_cnt;
        int          lane, idx;
        logic [31:0] src;
        in_ram = a < 32'(DEPTH_WORDS * 4);
        is_led = (a == MMIO_BASE);
        is_cnt = (a == CNT_ADDR);
        lane   = int'(a % 4);
        idx    = int'((a / 4) % DEPTH_WORDS);
        e      = (!b && lane != 0) || !(in_ram || is_led || is_cnt) || (is_cnt && w);
        rd     = mdl_rdata;
        if (e) begin
            rd = '0;
        end else if (w) begin
            if (in_ram && b)
                mdl_mem[idx] = (mdl_mem[idx] & ~(32'hFF << (8 * lane))) | ({24'h0, d[7:0]} << (8 * lane));
            else if (in_ram)
                mdl_mem[idx] = d;
            else
                mdl_led = d[7:0];
        end else begin
            src = in_ram ? mdl_mem[idx] : (is_led ? {24'h0, mdl_led} : cnt_val);
            rd  = b ? ((src >> (8 * lane)) & 32'hFF) : src;
        end
        mdl_rdata = rd;
    endtask

    // Drives one request, scrambles the bus while busy, and waits (bounded) for ready.
    task automatic applyStimulus(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] rd, output logic e, output int lat,
                                 output logic [31:0] edge_done);
        bus.req = 1'b1; bus.we = w; bus.byte_en = b; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.req = 1'($urandom); bus.we = 1'($urandom); bus.byte_en = 1'($urandom);
        bus.addr = $urandom; bus.wdata = $urandom;
        rd = '0; e = 1'b0; lat = -1; edge_done = edges;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.ready) begin
                lat = k - 1; rd = bus.rdata; e = bus.err; edge_done = edges;
                break;
            end
        end
        bus.req = 1'b0;
        @(negedge clk);
        checkOutput("ready_single_pulse", 32'(bus.ready), 32'd0);
        checkOutput("err_without_ready", 32'(bus.err), 32'd0);
    endtask

    task automatic access(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd_out);
        logic [31:0] rd, ed, exp_rd, cnt_val;
        logic        e, exp_e;
        int          lat;
        applyStimulus(w, b, a, d, rd, e, lat, ed);
        cnt_val = base_val + (ed - 32'd1 - base_edge);
        modelAccess(w, b, a, d, cnt_val, exp_e, exp_rd);
        checkOutput($sformatf("latency@%h", a), 32'(lat), 32'(WAIT_STATES + 1));
        checkOutput($sformatf("err@%h", a), 32'(e), 32'(exp_e));
        checkOutput($sformatf("rdata@%h", a), rd, exp_rd);
        checkOutput($sformatf("led_out@%h", a), 32'(led_out), 32'(mdl_led));
        rd_out = rd;
    endtask

    initial begin
        logic [31:0] rd, r1, r2, exp_rd, a, d;
        logic        w, b, e_unused;
        int          sel, pulses, second_j;
        logic        first_seen;

        bus.req = 1'b0; bus.we = 1'b0; bus.byte_en = 1'b0; bus.addr = '0; bus.wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 32'(bus.ready), 32'd0);
        checkOutput("reset_err", 32'(bus.err), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_rdata", bus.rdata, 32'd0);
        checkOutput("reset_led", 32'(led_out), 32'd0);
        reset = 1'b0; base_edge = edges; base_val = '0;

        for (int i = 0; i < int'(DEPTH_WORDS); i++)
            access(1'b1, 1'b0, 32'(i * 4), $urandom, rd);

        access(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, rd);
        access(1'b0, 1'b0, 32'h10, 32'h0, rd);
        checkOutput("word_rd_deadbeef", rd, 32'hDEAD_BEEF);

        access(1'b1, 1'b0, 32'h10, 32'h1122_3344, rd);
        access(1'b1, 1'b1, 32'h11, 32'h1234_56A5, rd);
        access(1'b0, 1'b1, 32'h10, 32'h0, rd); checkOutput("byte_rd_10", rd, 32'h44);
        access(1'b0, 1'b1, 32'h11, 32'h0, rd); checkOutput("byte_rd_11", rd, 32'hA5);
        access(1'b0, 1'b1, 32'h12, 32'h0, rd); checkOutput("byte_rd_12", rd, 32'h22);
        access(1'b0, 1'b1, 32'h13, 32'h0, rd); checkOutput("byte_rd_13", rd, 32'h11);
        access(1'b0, 1'b0, 32'h10, 32'h0, rd); checkOutput("word_rd_merged", rd, 32'h1122_A544);

        access(1'b0, 1'b0, 32'h12, 32'h0, rd);
        access(1'b1, 1'b0, 32'h400, 32'hCAFE_F00D, rd);
        access(1'b0, 1'b0, 32'h0, 32'h0, rd);

        access(1'b1, 1'b0, MMIO_BASE, 32'h0000_01FF, rd);
        checkOutput("led_after_1ff", 32'(led_out), 32'hFF);
        access(1'b0, 1'b0, MMIO_BASE, 32'h0, rd);
        checkOutput("led_readback", rd, 32'h0000_00FF);
        access(1'b1, 1'b0, CNT_ADDR, 32'h1234_5678, rd);

        access(1'b0, 1'b0, CNT_ADDR, 32'h0, r1);
        repeat (8) @(negedge clk);
        access(1'b0, 1'b0, CNT_ADDR, 32'h0, r2);
        checkOutput("cnt_diff", r2 - r1, 32'(10 + WAIT_STATES + 1));

        force dut.cycle_cnt = 32'hFFFF_FFFD;
        base_edge = edges; base_val = 32'hFFFF_FFFD;
        #1;
        release dut.cycle_cnt;
        access(1'b0, 1'b0, CNT_ADDR, 32'h0, rd);
        checkOutput("cnt_wrap_zero", rd, 32'h0);

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            w   = 1'($urandom);
            b   = 1'($urandom);
            d   = $urandom;
            if (sel <= 5) begin
                a = 32'($urandom_range(0, DEPTH_WORDS * 4 - 1));
                if (!b && $urandom_range(0, 3) != 0) a = a & ~32'h3;
            end else if (sel == 6) begin
                a = MMIO_BASE;
            end else if (sel == 7) begin
                a = CNT_ADDR;
            end else if (sel == 8) begin
                a = 32'(DEPTH_WORDS * 4) + 32'($urandom_range(0, 1000) * 4);
            end else begin
                a = MMIO_BASE + 32'($urandom_range(1, 3)) + 32'($urandom_range(1, 100) * 4);
            end
            access(w, b, a, d, rd);
        end

        access(1'b1, 1'b0, MMIO_BASE, 32'h0000_005A, rd);

        // req held high through the ready cycle: exactly one follow-up access.
        bus.req = 1'b1; bus.we = 1'b0; bus.byte_en = 1'b0; bus.addr = 32'h14; bus.wdata = '0;
        modelAccess(1'b0, 1'b0, 32'h14, 32'h0, 32'h0, e_unused, exp_rd);
        first_seen = 1'b0; r1 = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ready) begin first_seen = 1'b1; r1 = bus.rdata; break; end
        end
        checkOutput("hold_first_ready", 32'(first_seen), 32'd1);
        checkOutput("hold_first_rdata", r1, exp_rd);
        modelAccess(1'b0, 1'b0, 32'h14, 32'h0, 32'h0, e_unused, exp_rd);
        pulses = 0; second_j = 0; r2 = '0;
        for (int j = 1; j <= int'(WAIT_STATES) + 12; j++) begin
            @(negedge clk);
            if (j == 2) bus.req = 1'b0;
            if (bus.ready) begin pulses++; second_j = j; r2 = bus.rdata; end
        end
        checkOutput("hold_pulse_count", 32'(pulses), 32'd1);
        checkOutput("hold_second_timing", 32'(second_j), 32'(WAIT_STATES + 3));
        checkOutput("hold_second_rdata", r2, exp_rd);

        // Reset lands while a write to 0x20 is waiting.
        bus.req = 1'b1; bus.we = 1'b1; bus.byte_en = 1'b0; bus.addr = 32'h20; bus.wdata = ~mdl_mem[8];
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; base_edge = edges; base_val = '0; mdl_led = '0; mdl_rdata = '0;
        pulses = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (bus.ready) pulses++;
        end
        checkOutput("abort_no_ready", 32'(pulses), 32'd0);
        checkOutput("abort_led_zero", 32'(led_out), 32'd0);
        checkOutput("abort_rdata_zero", bus.rdata, 32'd0);
        checkOutput("abort_busy_zero", 32'(bus.busy), 32'd0);
        access(1'b0, 1'b0, 32'h20, 32'h0, rd);
        access(1'b0, 1'b0, CNT_ADDR, 32'h0, rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
